i2c_codec_target: RTL

- I2C target (responder) for the audio-codec I2C IP. It is the far end of the initiator whose SCL comes from the divided clock.
- Oversamples SCL/SDA on the fast system clock and decodes START, STOP, address, register-pointer and data bytes.
- Holds a small register file that the initiator writes and reads, with auto-increment.
- Used as an on-chip codec model for bring-up and simulation, and as a loopback target for the I2C master.

---
 rtl/i2c_codec_target_if.sv | 26 ++
 rtl/i2c_codec_target.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target_if.sv
// I2C codec target bus bundle: pin-level SCL/SDA plus the write-commit side channel.
interface i2c_codec_target_if #(
    parameter int unsigned NUM_REGS = 16
);
    localparam int unsigned PtrW = $clog2(NUM_REGS);

    logic            i_scl;
    logic            i_sda;
    logic            o_sda_oe;
    logic            o_wr_valid;
    logic [PtrW-1:0] o_wr_addr;
    logic [7:0]      o_wr_data;
    logic            o_busy;

    // Bus side: drives the wires, observes the target.
    modport master (
        output i_scl, i_sda,
        input  o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_busy
    );

    // Target side.
    modport slave (
        input  i_scl, i_sda,
        output o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data, o_busy
    );
endinterface

// File: rtl/i2c_codec_target.sv
// I2C target with a small auto-incrementing register file, oversampled on i_clk.
// Optional: define GLITCH_FILTER_EN for a 3-sample majority filter on SCL/SDA.
module i2c_codec_target #(
    parameter logic [6:0]  I2C_ADDR  = 7'h1A,
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input logic              i_clk,
    input logic              i_rst_n,
    i2c_codec_target_if.slave bus
);
    localparam int unsigned PtrW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StReg, StRegAck, StWdata, StWdataAck, StRdata, StRdataAck
    } state_e;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Reset: asynchronous assert, synchronous release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_v, sda_v;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.i_scl};
            sda_sync_q <= {sda_sync_q[0], bus.i_sda};
        end
    end

`ifdef GLITCH_FILTER_EN
    function automatic logic maj3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    // Majority of the last three synchronized samples, registered (+2 cycles, drops 1-cycle pulses).
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
        end
    end
    assign scl_v = scl_filt_q;
    assign sda_v = sda_filt_q;
`else
    assign scl_v = scl_sync_q[1];
    assign sda_v = sda_sync_q[1];
`endif

    state_e          state_q, state_d;
    logic [7:0]      sh_q, sh_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PtrW-1:0] ptr_q, ptr_d, ptr_inc;
    logic            oe_q, oe_d, busy_q, busy_d;
    logic            wr_valid_q, wr_valid_d;
    logic [PtrW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic            scl_prev_q, sda_prev_q;
    logic            scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0]      byte_in, rd_byte;

    assign scl_rise = scl_v & ~scl_prev_q;
    assign scl_fall = ~scl_v & scl_prev_q;
    assign start_ev = sda_prev_q & ~sda_v & scl_v & scl_prev_q;
    assign stop_ev  = ~sda_prev_q & sda_v & scl_v & scl_prev_q;
    assign byte_in  = {sh_q[6:0], sda_v};
    assign ptr_inc  = ptr_q + PtrW'(1);
    assign rd_byte  = regs_q[ptr_q];

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sh_q       <= 8'h00;
            cnt_q      <= 4'd0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            scl_prev_q <= scl_v;
            sda_prev_q <= sda_v;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Protocol FSM: bits shift in on SCL rise, SDA drive changes only on SCL fall.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        if (stop_ev) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else if (start_ev) begin
            state_d = StAddr;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StReg, StWdata: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == StAddr) begin
                                if (byte_in[7:1] == I2C_ADDR) begin
                                    state_d = StAddrAck;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = StIdle;
                                end
                            end else if (state_q == StReg) begin
                                ptr_d   = byte_in[PtrW-1:0];
                                state_d = StRegAck;
                            end else begin
                                state_d = StWdataAck;
                            end
                        end
                    end
                end
                // First fall after the byte asserts ACK, the second one ends it.
                StAddrAck, StRegAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (state_q == StAddrAck && sh_q[0]) begin
                            state_d = StRdata;
                            sh_d    = rd_byte;
                            oe_d    = ~rd_byte[7];
                            cnt_d   = 4'd0;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = (state_q == StAddrAck) ? StReg : StWdata;
                            if (state_q == StWdataAck) begin
                                regs_d[ptr_q] = sh_q;
                                wr_valid_d    = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = sh_q;
                                ptr_d         = ptr_inc;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = StRdataAck;
                        end else begin
                            oe_d = ~sh_q[7];
                        end
                    end
                end
                // Byte has been transferred either way; pointer advances past it.
                StRdataAck: begin
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (!sda_v) begin
                            sh_d    = regs_q[ptr_inc];
                            cnt_d   = 4'd0;
                            state_d = StRdata;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.o_sda_oe   = oe_q;
    assign bus.o_wr_valid = wr_valid_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_busy     = busy_q;
endmodule
